osc_freq_meter: RTL and testbench

Receiving end for the on-chip oscillator (OSCD_CORE) output: measures an asynchronous oscillator signal against the fabric clock. It synchronises `osc_in`, detects rising edges, and counts them over a fixed gate window of `GATE_CYCLES` clk cycles. Supports single-shot and continuous modes. Used in hardware bring-up images to confirm the oscillator divider settings decoded by the OSCD fuzzer.

---
 rtl/osc_meter_pkg.sv | 15 +
 rtl/sync_rise_det.sv | 26 ++
 rtl/osc_freq_meter.sv | 116 +++++++++++
 tb/tb_osc_freq_meter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_meter_pkg.sv
// Shared types and helpers for the oscillator frequency meter.
package osc_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_REPORT = 2'd2
  } meter_state_t;

  // Width needed to count gate cycles 0..gate_cycles-1.
  function automatic int gate_cnt_width(input int gate_cycles);
    return (gate_cycles < 2) ? 1 : $clog2(gate_cycles);
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/osc_freq_meter.sv
// Counts synchronised rising edges of osc_in over a fixed gate of GATE_CYCLES clk cycles.
module osc_freq_meter
  import osc_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             valid
);

  localparam int               GW        = gate_cnt_width(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  meter_state_t     state;
  meter_state_t     state_nxt;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_nxt;
  logic             ovf;
  logic             ovf_nxt;
  logic             cont_q;
  logic             rise;
  logic             gate_last;
  logic             edge_sat;

  sync_rise_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(osc_in),
    .rise    (rise)
  );

  assign gate_last = (state == ST_GATE) && (gate_cnt == GATE_LAST);
  assign edge_sat  = rise && (edge_cnt == CNT_MAX);
  assign edge_nxt  = edge_sat ? edge_cnt : edge_cnt + {{(CNT_W-1){1'b0}}, rise};
  assign ovf_nxt   = ovf | edge_sat;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start) state_nxt = ST_GATE;
      ST_GATE:   if (gate_gate_done()) state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = cont_q ? ST_GATE : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  function automatic logic gate_gate_done();
    return gate_last;
  endfunction

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_REPORT);
  end

  // The report registers load on the edge leaving the last gate cycle so they
  // are already valid during the REPORT cycle, alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
      cont_q   <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            cont_q   <= continuous;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
          end
        end
        ST_GATE: begin
          gate_cnt <= gate_cnt + GW'(1);
          edge_cnt <= edge_nxt;
          ovf      <= ovf_nxt;
          if (gate_last) begin
            count    <= edge_nxt;
            overflow <= ovf_nxt;
            valid    <= 1'b1;
          end
        end
        ST_REPORT: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_freq_meter.sv
// Bench for osc_freq_meter: two instances (small and saturating counter) share one stimulus.
module tb_osc_freq_meter;

  localparam int GA = 16;
  localparam int CA = 8;
  localparam int GB = 64;
  localparam int CB = 4;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic osc_in = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;

  logic          a_busy, a_done, a_overflow, a_valid;
  logic [CA-1:0] a_count;
  logic          b_busy, b_done, b_overflow, b_valid;
  logic [CB-1:0] b_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit hist [0:65535];
  logic [CA-1:0] exp_q[$];

  int osc_mode = 0;
  int osc_level = 0;
  int osc_half = 2;
  int ph = 0;

  osc_freq_meter #(.GATE_CYCLES(GA), .CNT_W(CA), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .continuous(continuous),
    .busy(a_busy), .done(a_done), .count(a_count), .overflow(a_overflow), .valid(a_valid)
  );

  osc_freq_meter #(.GATE_CYCLES(GB), .CNT_W(CB), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .continuous(continuous),
    .busy(b_busy), .done(b_done), .count(b_count), .overflow(b_overflow), .valid(b_valid)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // cycle k is the interval after posedge k; hist[k] is osc_in seen at posedge k
  always @(posedge clk) begin
    cyc = cyc + 1;
    hist[cyc] = osc_in;
  end

  // oscillator driver: 0 static, 1 square wave, 2 random (period >= 3)
  always begin
    @(posedge clk);
    #1;
    if (osc_mode == 0) begin
      osc_in = osc_level[0];
    end else if (osc_mode == 1) begin
      if (ph >= osc_half - 1) begin
        ph = 0;
        osc_in = ~osc_in;
      end else begin
        ph++;
      end
    end else begin
      if (ph <= 0) begin
        osc_in = ~osc_in;
        ph = osc_in ? int'($urandom_range(0, 4)) : int'($urandom_range(1, 4));
      end else begin
        ph--;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_start(input logic cont, output int p);
    @(posedge clk);
    #1;
    start = 1'b1;
    continuous = cont;
    @(posedge clk);
    #1;
    p = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done_a(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (a_done) seen = 1'b1;
    end
  endtask

  // Reference: synchronised rising edges falling in cycles first..last.
  function automatic int model_edges(input int first, input int last);
    int n = 0;
    for (int k = first; k <= last; k++)
      if (hist[k-SYNC+1] && !hist[k-SYNC]) n++;
    return n;
  endfunction

  typedef struct {
    int do_rst;
    int mode;
    int level;
    int half;
    int exp_a;
    int ovf_a;
    int exp_b;
    int ovf_b;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int p;
    int da;
    int db;
    int n;
    int w;
    bit seen;
    bit sa;
    bit sb;
    int ca, oa, cb, ob;

    vecs[0] = '{0, 1, 0, 2, 4, 0, 15, 1};
    vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 4, 2, 0, 8, 0};
    vecs[3] = '{1, 0, 1, 0, 0, 0, 0, 0};
    vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{0, 1, 0, 8, 1, 0, 4, 0};

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_busy_a", a_busy, 0);
    chk("rst_done_a", a_done, 0);
    chk("rst_count_a", a_count, 0);
    chk("rst_ovf_a", a_overflow, 0);
    chk("rst_valid_a", a_valid, 0);
    chk("rst_busy_b", b_busy, 0);
    chk("rst_count_b", b_count, 0);
    chk("rst_valid_b", b_valid, 0);

    // busy/done timing with osc period 4
    osc_mode = 1;
    osc_half = 2;
    repeat (20) @(negedge clk);
    do_start(1'b0, p);
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk);
      chk("t1_busy", a_busy, (i <= GA) ? 1 : 0);
      chk("t1_done", a_done, (i == GA) ? 1 : 0);
      if (i == GA) begin
        chk("t1_count", a_count, 4);
        chk("t1_ovf", a_overflow, 0);
        chk("t1_valid", a_valid, 1);
      end
    end
    chk("t1_count_held", a_count, 4);

    // table-driven single shots on both instances
    for (int v = 0; v < 6; v++) begin
      osc_mode = vecs[v].mode;
      osc_level = vecs[v].level;
      osc_half = vecs[v].half;
      if (vecs[v].do_rst != 0) do_reset();
      repeat (20) @(negedge clk);
      do_start(1'b0, p);
      sa = 1'b0;
      sb = 1'b0;
      for (int i = 0; i < 120; i++) begin
        @(negedge clk);
        if (a_done && !sa) begin
          sa = 1'b1; ca = a_count; oa = a_overflow;
        end
        if (b_done && !sb) begin
          sb = 1'b1; cb = b_count; ob = b_overflow;
        end
        if (sa && sb) break;
      end
      chk($sformatf("vec%0d_done_a", v), sa, 1);
      chk($sformatf("vec%0d_done_b", v), sb, 1);
      if (sa) begin
        chk($sformatf("vec%0d_count_a", v), ca, vecs[v].exp_a);
        chk($sformatf("vec%0d_ovf_a", v), oa, vecs[v].ovf_a);
      end
      if (sb) begin
        chk($sformatf("vec%0d_count_b", v), cb, vecs[v].exp_b);
        chk($sformatf("vec%0d_ovf_b", v), ob, vecs[v].ovf_b);
      end
      chk($sformatf("vec%0d_valid_b", v), b_valid, 1);
    end

    // continuous mode, osc period 8, ignored start pulses while busy
    do_reset();
    osc_mode = 1;
    osc_half = 4;
    repeat (20) @(negedge clk);
    do_start(1'b1, p);
    da = p + GA;
    w = 0;
    while (w < 6) begin
      @(negedge clk);
      if (cyc == da) begin
        chk("cont_done", a_done, 1);
        chk("cont_count", a_count, 2);
        da += GA + 1;
        w++;
      end else begin
        chk("cont_no_done", a_done, 0);
        chk("cont_busy", a_busy, 1);
      end
      if ((cyc == da - 5) && (w == 1 || w == 3)) begin
        start = 1'b1;
        continuous = 1'b0;
      end else begin
        start = 1'b0;
      end
    end

    // reset in the middle of a gate
    do_reset();
    osc_mode = 1;
    osc_half = 2;
    repeat (20) @(negedge clk);
    do_start(1'b0, p);
    wait_done_a(40, seen);
    chk("mid_pre_seen", seen, 1);
    chk("mid_pre_valid", a_valid, 1);
    repeat (4) @(negedge clk);
    do_start(1'b0, p);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", a_busy, 0);
    chk("mid_done", a_done, 0);
    chk("mid_count", a_count, 0);
    chk("mid_valid", a_valid, 0);
    chk("mid_ovf_b", b_overflow, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("mid_no_done", a_done, 0);
      chk("mid_idle", a_busy, 0);
    end
    do_start(1'b0, p);
    wait_done_a(40, seen);
    chk("mid_fresh_seen", seen, 1);
    chk("mid_fresh_count", a_count, 4);
    chk("mid_fresh_valid", a_valid, 1);

    // random oscillator, continuous windows on both instances
    do_reset();
    osc_mode = 2;
    repeat (20) @(negedge clk);
    do_start(1'b1, p);
    da = p + GA;
    db = p + GB;
    w = 0;
    while (w < 1000) begin
      @(negedge clk);
      if (cyc == da) begin
        exp_q.push_back(CA'(model_edges(da - GA, da - 1)));
        chk("rand_done_a", a_done, 1);
        chk("rand_count_a", a_count, exp_q.pop_front());
        chk("rand_ovf_a", a_overflow, 0);
        da += GA + 1;
        w++;
      end else begin
        chk("rand_no_done_a", a_done, 0);
      end
      if (cyc == db) begin
        n = model_edges(db - GB, db - 1);
        chk("rand_done_b", b_done, 1);
        chk("rand_count_b", b_count, (n > 15) ? 15 : n);
        chk("rand_ovf_b", b_overflow, (n > 15) ? 1 : 0);
        db += GB + 1;
      end else begin
        chk("rand_no_done_b", b_done, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
